fir_channel_scheduler: RTL

- Time-shares one FIR filter engine between the RED and IR sample streams coming out of the LED/ADC controller.
- Replaces the two parallel filter instances.
- Buffers one pending sample per channel and arbitrates round-robin.
- Issues each sample to the engine with a channel tag, then routes the filtered result back to a per-channel output register with a valid strobe.

---
 rtl/fir_channel_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fir_channel_scheduler.sv
// Shares one FIR engine between the RED and IR sample streams: one pending slot per
// channel, round-robin grant, tagged job issue, and per-channel result registers.
module fir_channel_scheduler #(
    parameter int SAMPLE_W    = 8,
    parameter int RESULT_W    = 20,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                red_valid,
    input  logic [SAMPLE_W-1:0] red_sample,
    input  logic                ir_valid,
    input  logic [SAMPLE_W-1:0] ir_sample,
    output logic                fir_start,
    output logic                fir_ch,
    output logic [SAMPLE_W-1:0] fir_sample,
    input  logic                fir_done,
    input  logic [RESULT_W-1:0] fir_result,
    output logic [RESULT_W-1:0] out_red,
    output logic                out_red_valid,
    output logic [RESULT_W-1:0] out_ir,
    output logic                out_ir_valid,
    input  logic                err_clr,
    output logic [1:0]          overrun,
    output logic                timeout_err,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    // Handshake: every *_valid / fir_start / fir_done is a one-cycle strobe with no
    // back-pressure; the data beside it is meaningful only in the strobe cycle.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

    state_t              state, state_next;
    logic                pend_red, pend_ir;
    logic [SAMPLE_W-1:0] buf_red, buf_ir;
    logic                last_grant;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                grant, grant_ch;
    logic                take, expire;
    logic                consume_red, consume_ir;

    assign cnt_inc     = cnt + 1'b1;
    assign consume_red = grant && !grant_ch;
    assign consume_ir  = grant && grant_ch;
    assign fir_start   = (state == ISSUE);
    assign busy        = (state != IDLE);
    assign state_dbg   = state;

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_ch   = 1'b0;
        take       = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (pend_red || pend_ir) begin
                    grant      = 1'b1;
                    // On a tie the channel that did not win last time goes first.
                    grant_ch   = (pend_red && pend_ir) ? !last_grant : pend_ir;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (fir_done) begin
                    take       = 1'b1;
                    state_next = IDLE;
                end else if (cnt_inc == TERM) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pend_red      <= 1'b0;
            pend_ir       <= 1'b0;
            buf_red       <= '0;
            buf_ir        <= '0;
            last_grant    <= 1'b1;
            cnt           <= '0;
            fir_ch        <= 1'b0;
            fir_sample    <= '0;
            out_red       <= '0;
            out_ir        <= '0;
            out_red_valid <= 1'b0;
            out_ir_valid  <= 1'b0;
            overrun       <= 2'b00;
            timeout_err   <= 1'b0;
        end else begin
            state <= state_next;

            // A sample arriving while its slot is being granted refills the slot.
            if (red_valid) begin
                buf_red  <= red_sample;
                pend_red <= 1'b1;
            end else if (consume_red) begin
                pend_red <= 1'b0;
            end
            if (ir_valid) begin
                buf_ir  <= ir_sample;
                pend_ir <= 1'b1;
            end else if (consume_ir) begin
                pend_ir <= 1'b0;
            end

            if (grant) begin
                fir_ch     <= grant_ch;
                fir_sample <= grant_ch ? buf_ir : buf_red;
                last_grant <= grant_ch;
            end

            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt_inc;
            end

            out_red_valid <= take && !fir_ch;
            out_ir_valid  <= take && fir_ch;
            if (take && !fir_ch) out_red <= fir_result;
            if (take && fir_ch)  out_ir  <= fir_result;

            if (err_clr) begin
                overrun     <= 2'b00;
                timeout_err <= 1'b0;
            end else begin
                if (red_valid && pend_red && !consume_red) overrun[0] <= 1'b1;
                if (ir_valid && pend_ir && !consume_ir)    overrun[1] <= 1'b1;
                if (expire) timeout_err <= 1'b1;
            end
        end
    end

endmodule
